fb_pingpong_sched: RTL and testbench



---
 rtl/fb_sched_pkg.sv | 28 ++
 rtl/fb_bank_tracker.sv | 32 +++
 rtl/fb_pingpong_sched.sv | 166 ++++++++++++++++
 tb/tb_fb_pingpong_sched.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fb_sched_pkg.sv
// rtl/fb_sched_pkg.sv - shared encodings for the ping-pong frame-buffer scheduler
package fb_sched_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_READING = 2'd3
  } bank_state_e;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_ACTIVE = 2'd1,
    W_DROP   = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_RUN   = 2'd2,
    R_FLUSH = 2'd3
  } rd_state_e;

  localparam int unsigned WIDTH_DEF  = 480;
  localparam int unsigned HEIGHT_DEF = 272;
  localparam int unsigned FRAME_PIX  = WIDTH_DEF * HEIGHT_DEF;

endpackage

// File: rtl/fb_bank_tracker.sv
// rtl/fb_bank_tracker.sv - lifecycle state of one frame bank
module fb_bank_tracker
  import fb_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        set_fill,
  input  logic        set_full,
  input  logic        set_read,
  input  logic        rel,
  output bank_state_e state
);

  bank_state_e state_q, state_d;

  // set_fill is last so a bank released and refilled in the same cycle ends up FILLING
  always_comb begin
    state_d = state_q;
    if (rel)      state_d = BANK_EMPTY;
    if (set_full) state_d = BANK_FULL;
    if (set_read) state_d = BANK_READING;
    if (set_fill) state_d = BANK_FILLING;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BANK_EMPTY;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/fb_pingpong_sched.sv
// rtl/fb_pingpong_sched.sv - ping-pong bank scheduler between camera writer and window reader
module fb_pingpong_sched
  import fb_sched_pkg::*;
#(
  parameter int WIDTH  = 480,
  parameter int HEIGHT = 272,
  parameter int ADDR_W = 17,
  parameter int CNT_W  = $clog2(WIDTH * HEIGHT)
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iEnable,
  input  logic              iCamSof,
  input  logic              iCamEof,
  output logic              oWrAllow,
  output logic [ADDR_W:0]   oWrBase,
  output logic              oWinEn,
  output logic [ADDR_W:0]   oRdBase,
  input  logic              iWinValid,
  input  logic              iDsReady,
  output logic              oRdDone,
  output logic              oFrameErr,
  output logic [7:0]        oDropCnt
);

  localparam logic [ADDR_W:0]  BANK1_BASE = (ADDR_W + 1)'(WIDTH * HEIGHT);
  localparam logic [CNT_W-1:0] LAST_PIX   = CNT_W'(WIDTH * HEIGHT - 1);

  wr_state_e        wr_q, wr_d;
  rd_state_e        rd_q, rd_d;
  bank_state_e      bank_st [2];
  logic [1:0]       set_fill, set_full, set_read, rel;
  logic [1:0]       full_now, empty_vis;
  logic             wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, old_q, old_d;
  logic             other, pick, eval_sof, win_en, rd_done;
  logic [ADDR_W:0]  wr_base_q, wr_base_d, rd_base_q, rd_base_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       drop_q, drop_d;
  logic             err_q, err_d;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fb_bank_tracker u_bank (
      .clk      (iClk),
      .rst      (iRst),
      .set_fill (set_fill[b]),
      .set_full (set_full[b]),
      .set_read (set_read[b]),
      .rel      (rel[b]),
      .state    (bank_st[b])
    );
    assign full_now[b]  = (bank_st[b] == BANK_FULL);
    // a bank being released this cycle already counts as free for the writer
    assign empty_vis[b] = (bank_st[b] == BANK_EMPTY) || rel[b];
  end

  always_comb begin
    rd_d      = rd_q;
    rd_bank_d = rd_bank_q;
    rd_base_d = rd_base_q;
    cnt_d     = cnt_q;
    set_read  = '0;
    rel       = '0;
    win_en    = 1'b0;
    rd_done   = 1'b0;
    case (rd_q)
      R_IDLE: begin
        if (iEnable && (|full_now)) begin
          rd_bank_d           = (&full_now) ? old_q : full_now[1];
          set_read[rd_bank_d] = 1'b1;
          rd_base_d           = rd_bank_d ? BANK1_BASE : '0;
          rd_d                = R_START;
        end
      end
      R_START: rd_d = R_RUN;
      R_RUN: begin
        win_en = iDsReady & iEnable;
        if (iWinValid && win_en) begin
          if (cnt_q == LAST_PIX) begin
            cnt_d = '0;
            rd_d  = R_FLUSH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      R_FLUSH: begin
        rel[rd_bank_q] = 1'b1;
        rd_done        = 1'b1;
        rd_d           = R_IDLE;
      end
      default: rd_d = R_IDLE;
    endcase
  end

  // EOF is retired first so a coincident SOF sees the post-EOF bank states
  always_comb begin
    wr_d      = wr_q;
    wr_bank_d = wr_bank_q;
    wr_base_d = wr_base_q;
    old_d     = old_q;
    drop_d    = drop_q;
    err_d     = 1'b0;
    set_fill  = '0;
    set_full  = '0;
    other     = ~wr_bank_q;
    eval_sof  = (wr_q == W_IDLE);
    if (iCamEof && (wr_q == W_ACTIVE)) begin
      set_full[wr_bank_q] = 1'b1;
      old_d               = full_now[other] ? other : wr_bank_q;
      wr_d                = W_IDLE;
      eval_sof            = 1'b1;
    end else if (iCamEof && (wr_q == W_DROP)) begin
      wr_d     = W_IDLE;
      eval_sof = 1'b1;
    end
    pick = empty_vis[other] ? other : wr_bank_q;
    if (iCamSof) begin
      if (eval_sof && (|empty_vis)) begin
        wr_bank_d      = pick;
        set_fill[pick] = 1'b1;
        wr_base_d      = pick ? BANK1_BASE : '0;
        wr_d           = W_ACTIVE;
      end else if (wr_q == W_ACTIVE && !eval_sof) begin
        err_d = 1'b1;
      end else begin
        wr_d   = W_DROP;
        drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      wr_q      <= W_IDLE;
      rd_q      <= R_IDLE;
      wr_bank_q <= 1'b1;
      rd_bank_q <= 1'b0;
      old_q     <= 1'b0;
      wr_base_q <= '0;
      rd_base_q <= '0;
      cnt_q     <= '0;
      drop_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      old_q     <= old_d;
      wr_base_q <= wr_base_d;
      rd_base_q <= rd_base_d;
      cnt_q     <= cnt_d;
      drop_q    <= drop_d;
      err_q     <= err_d;
    end
  end

  assign oWrAllow  = (wr_q == W_ACTIVE);
  assign oWrBase   = wr_base_q;
  assign oWinEn    = win_en;
  assign oRdBase   = rd_base_q;
  assign oRdDone   = rd_done;
  assign oFrameErr = err_q;
  assign oDropCnt  = drop_q;

endmodule

// File: tb/tb_fb_pingpong_sched.sv
// tb/tb_fb_pingpong_sched.sv - scoreboard bench for fb_pingpong_sched with a 4x3 frame
module tb_fb_pingpong_sched;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 17;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0, sof = 1'b0, eof = 1'b0, wv = 1'b0, dsr = 1'b0;
  logic          wr_allow, win_en, rd_done, frame_err;
  logic [AW:0]   wr_base, rd_base;
  logic [7:0]    drop_cnt;

  int            n_cmp = 0;
  int            n_fail = 0;
  int            seen_valid = 0;
  logic [AW:0]   done_q [$];
  logic [AW:0]   err_q [$];

  fb_pingpong_sched #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .iClk      (clk),
    .iRst      (rst),
    .iEnable   (en),
    .iCamSof   (sof),
    .iCamEof   (eof),
    .oWrAllow  (wr_allow),
    .oWrBase   (wr_base),
    .oWinEn    (win_en),
    .oRdBase   (rd_base),
    .iWinValid (wv),
    .iDsReady  (dsr),
    .oRdDone   (rd_done),
    .oFrameErr (frame_err),
    .oDropCnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
  endtask

  task automatic feed(input int n);
    wv = 1'b1;
    repeat (n) tick();
    wv = 1'b0;
  endtask

  // monitor: pops expected pulses and checks them against what the DUT shows
  always @(negedge clk) begin
    if (rst) begin
      seen_valid = 0;
    end else begin
      if (win_en && wv) seen_valid++;
      if (rd_done) begin
        if (done_q.size() == 0) begin
          chk("rd_done_unexpected", 1, 0);
        end else begin
          chk("rd_done_base", rd_base, done_q.pop_front());
          chk("rd_done_count", seen_valid, NPIX);
        end
        seen_valid = 0;
      end
      if (frame_err) begin
        if (err_q.size() == 0) chk("frame_err_unexpected", 1, 0);
        else                   chk("frame_err_wr_base", wr_base, err_q.pop_front());
      end
    end
  end

  initial begin
    // reset values
    tick();
    chk("rst_wr_allow", wr_allow, 0);
    chk("rst_wr_base", wr_base, 0);
    chk("rst_win_en", win_en, 0);
    chk("rst_rd_base", rd_base, 0);
    chk("rst_rd_done", rd_done, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_drop", drop_cnt, 0);
    rst = 1'b0;

    // single frame into bank 0, read back
    en = 1'b1; dsr = 1'b1;
    sof = 1'b1; tick(); sof = 1'b0;
    chk("t1_wr_allow", wr_allow, 1);
    chk("t1_wr_base", wr_base, 0);
    repeat (10) tick();
    eof = 1'b1; tick(); eof = 1'b0;
    chk("t1_wr_allow_off", wr_allow, 0);
    chk("t1_win_en_idle", win_en, 0);
    tick();
    chk("t1_win_en_start", win_en, 0);
    chk("t1_rd_base", rd_base, 0);
    tick();
    chk("t1_win_en_run", win_en, 1);
    done_q.push_back(0);
    feed(NPIX);
    tick(); tick();

    // back-to-back frames while read is stalled, third frame dropped
    do_reset();
    dsr = 1'b0;
    sof = 1'b1; tick(); sof = 1'b0;
    chk("t2_wr_base_b0", wr_base, 0);
    tick();
    eof = 1'b1; tick(); eof = 1'b0;
    tick(); tick();
    sof = 1'b1; tick(); sof = 1'b0;
    chk("t2_wr_base_b1", wr_base, 18'd12);
    tick();
    eof = 1'b1; tick(); eof = 1'b0;
    sof = 1'b1; tick(); sof = 1'b0;
    chk("t2_drop1", drop_cnt, 1);
    chk("t2_wr_allow_drop", wr_allow, 0);
    repeat (3) tick();
    chk("t2_wr_allow_drop2", wr_allow, 0);
    sof = 1'b1; repeat (300) tick(); sof = 1'b0;
    chk("t2_drop_sat", drop_cnt, 255);
    eof = 1'b1; tick(); eof = 1'b0;
    chk("t2_wr_allow_after_eof", wr_allow, 0);
    dsr = 1'b1;
    done_q.push_back(0);
    feed(NPIX);
    tick();
    chk("t2_rd_base_hold", rd_base, 0);
    tick();
    chk("t2_rd_base_b1", rd_base, 18'd12);
    tick();

    // ready toggling every cycle during the bank-1 read
    done_q.push_back(18'd12);
    wv = 1'b1;
    for (int i = 0; i < 2 * NPIX - 1; i++) begin
      dsr = (i % 2 == 0);
      #1;
      chk("t3_win_en", win_en, dsr);
      tick();
    end
    wv = 1'b0; dsr = 1'b1;
    tick(); tick();

    // SOF coincident with the release of the bank being read
    do_reset();
    dsr = 1'b0;
    sof = 1'b1; tick(); sof = 1'b0;
    eof = 1'b1; tick(); eof = 1'b0;
    sof = 1'b1; tick(); sof = 1'b0;
    tick();
    eof = 1'b1; tick(); eof = 1'b0;
    dsr = 1'b1;
    done_q.push_back(0);
    feed(NPIX);
    sof = 1'b1; tick(); sof = 1'b0;
    chk("t4_drop_none", drop_cnt, 0);
    chk("t4_wr_allow", wr_allow, 1);
    chk("t4_wr_base", wr_base, 0);
    dsr = 1'b0;
    tick();
    chk("t4_rd_base_b1", rd_base, 18'd12);

    // repeated SOF without EOF, then EOF makes bank 0 readable
    err_q.push_back(0);
    sof = 1'b1; tick(); sof = 1'b0;
    chk("t5_wr_base", wr_base, 0);
    chk("t5_wr_allow", wr_allow, 1);
    tick();
    eof = 1'b1; tick(); eof = 1'b0;
    dsr = 1'b1;
    done_q.push_back(18'd12);
    feed(NPIX);
    tick();
    chk("t5_rd_base_hold", rd_base, 18'd12);
    tick();
    chk("t5_rd_base_b0", rd_base, 0);

    // async reset mid-read discards both banks
    sof = 1'b1; tick(); sof = 1'b0;
    chk("t6_wr_base_b1", wr_base, 18'd12);
    eof = 1'b1; tick(); eof = 1'b0;
    chk("t6_win_en_pre", win_en, 1);
    sof = 1'b1; tick(); sof = 1'b0;
    chk("t6_drop_pre", drop_cnt, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_win_en", win_en, 0);
    chk("t6_rst_wr_base", wr_base, 0);
    chk("t6_rst_drop", drop_cnt, 0);
    chk("t6_rst_wr_allow", wr_allow, 0);
    chk("t6_rst_rd_base", rd_base, 0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("t6_no_read", win_en, 0);
    sof = 1'b1; tick(); sof = 1'b0;
    chk("t6_wr_base_new", wr_base, 0);
    tick();
    eof = 1'b1; tick(); eof = 1'b0;
    tick();
    chk("t6_win_en_start", win_en, 0);
    tick();
    chk("t6_win_en_run", win_en, 1);
    chk("t6_rd_base", rd_base, 0);
    done_q.push_back(0);
    feed(NPIX);
    tick(); tick();

    chk("done_q_drained", done_q.size(), 0);
    chk("err_q_drained", err_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
